// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: shared constants and types for the clkdiv_bank divider bank.
//   CNT_W_DEF    default counter/divisor width
//   NCH_DEF      default channel count
//   DIV_*        standard timebase divisors at 50 MHz
//   DIV_RST_DEF  default packed reset divisors, channel 0 in the low slice
//   ch_sel_w()   width of the channel-select field (minimum 1)
package clkdiv_pkg;

  localparam int unsigned CNT_W_DEF = 32;
  localparam int unsigned NCH_DEF   = 4;

  typedef logic [CNT_W_DEF-1:0] div_t;

  localparam div_t DIV_1MS   = 32'd49999;
  localparam div_t DIV_20MS  = 32'd999999;
  localparam div_t DIV_10KHZ = 32'd4999;
  localparam div_t DIV_05HZ  = 32'd99999999;

  // Channel 0 = 1 ms, 1 = 20 ms, 2 = 10 kHz, 3 = 0.5 Hz.
  localparam logic [NCH_DEF*CNT_W_DEF-1:0] DIV_RST_DEF =
    {DIV_05HZ, DIV_10KHZ, DIV_20MS, DIV_1MS};

  function automatic int unsigned ch_sel_w(input int unsigned n);
    int unsigned w;
    if (n > 32'd1) begin
      w = $clog2(n);
    end else begin
      w = 32'd1;
    end
    return w;
  endfunction

endpackage

// File: rtl/clkdiv_chan.sv
// clkdiv_chan: one programmable divider channel.
//   clk_i     system clock
//   rst_i     asynchronous reset, active-high
//   en_i      run enable; low holds the channel cleared and applies writes at once
//   sync_i    restart/phase-align (present only with CLKDIV_SYNC_EN defined)
//   wr_i      divisor write strobe already decoded for this channel
//   wr_div_i  new divisor
//   tick_o    one-cycle pulse every D+1 cycles
//   clk_o     square wave toggling on each tick
//   pend_o    shadow divisor waiting for the next period boundary
// Configuration macro: CLKDIV_SYNC_EN.
module clkdiv_chan
  import clkdiv_pkg::*;
#(
  parameter int unsigned          CNT_W    = CNT_W_DEF,
  parameter logic [CNT_W-1:0]     DIV_INIT = {CNT_W{1'b0}}
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
`ifdef CLKDIV_SYNC_EN
  input  logic             sync_i,
`endif
  input  logic             wr_i,
  input  logic [CNT_W-1:0] wr_div_i,
  output logic             tick_o,
  output logic             clk_o,
  output logic             pend_o
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] shd_q, shd_d;
  logic             pend_q, pend_d;
  logic             tick_q, tick_d;
  logic             clk_q, clk_d;
  logic             term_s;
  logic             restart_s;

`ifdef CLKDIV_SYNC_EN
  assign restart_s = ~en_i | sync_i;
`else
  assign restart_s = ~en_i;
`endif

  assign term_s = (cnt_q == div_q);

  // Next-state logic. While pend is low the shadow always equals the active
  // divisor, so every reload point can simply copy the shadow (or a
  // coincident write) into D without looking at pend.
  always_comb begin
    cnt_d  = cnt_q;
    div_d  = div_q;
    shd_d  = shd_q;
    pend_d = pend_q;
    tick_d = 1'b0;
    clk_d  = clk_q;
    if (restart_s) begin
      // Disabled or aligning: clear the period and take the newest divisor.
      cnt_d  = CNT_ZERO;
      tick_d = 1'b0;
      clk_d  = 1'b0;
      pend_d = 1'b0;
      if (wr_i) begin
        shd_d = wr_div_i;
        div_d = wr_div_i;
      end else begin
        div_d = shd_q;
      end
    end else if (term_s) begin
      // Period boundary: tick, toggle, reload.
      cnt_d  = CNT_ZERO;
      tick_d = 1'b1;
      clk_d  = ~clk_q;
      pend_d = 1'b0;
      if (wr_i) begin
        shd_d = wr_div_i;
        div_d = wr_div_i;
      end else begin
        div_d = shd_q;
      end
    end else begin
      cnt_d  = cnt_q + CNT_ONE;
      tick_d = 1'b0;
      if (wr_i) begin
        shd_d  = wr_div_i;
        pend_d = 1'b1;
      end else begin
        pend_d = pend_q;
      end
    end
  end

  // Channel state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= CNT_ZERO;
      div_q  <= DIV_INIT;
      shd_q  <= DIV_INIT;
      pend_q <= 1'b0;
      tick_q <= 1'b0;
      clk_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      shd_q  <= shd_d;
      pend_q <= pend_d;
      tick_q <= tick_d;
      clk_q  <= clk_d;
    end
  end

  assign tick_o = tick_q;
  assign clk_o  = clk_q;
  assign pend_o = pend_q;

endmodule

// File: rtl/clkdiv_bank.sv
// clkdiv_bank: bank of NCH independent runtime-programmable clock dividers.
//   clk_i      system clock
//   rst_i      asynchronous reset, active-high
//   en_i       per-channel run enable [NCH]
//   sync_i     restart and phase-align all enabled channels
//   wr_en_i    divisor write strobe
//   wr_ch_i    target channel; values >= NCH are ignored
//   wr_div_i   new divisor [CNT_W]
//   tick_o     one-cycle pulse per channel period [NCH]
//   clk_out_o  50% square wave per channel [NCH]
//   pend_o     divisor written but not yet applied [NCH]
// Configuration macro: CLKDIV_SYNC_EN (undefined -> sync_i ignored).
module clkdiv_bank
  import clkdiv_pkg::*;
#(
  parameter int unsigned              NCH     = NCH_DEF,
  parameter int unsigned              CNT_W   = CNT_W_DEF,
  parameter logic [NCH*CNT_W-1:0]     DIV_RST = DIV_RST_DEF,
  localparam int unsigned             WCH_W   = ch_sel_w(NCH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [NCH-1:0]   en_i,
  input  logic             sync_i,
  input  logic             wr_en_i,
  input  logic [WCH_W-1:0] wr_ch_i,
  input  logic [CNT_W-1:0] wr_div_i,
  output logic [NCH-1:0]   tick_o,
  output logic [NCH-1:0]   clk_out_o,
  output logic [NCH-1:0]   pend_o
);

  localparam logic [WCH_W:0] NCH_L = (WCH_W+1)'(NCH);

  logic wr_ok_s;

  // Out-of-range channel numbers must not alias onto a real channel.
  assign wr_ok_s = wr_en_i & ({1'b0, wr_ch_i} < NCH_L);

`ifndef CLKDIV_SYNC_EN
  logic unused_sync_s;
  assign unused_sync_s = sync_i;
`endif

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    localparam logic [WCH_W-1:0] CH_IDX = WCH_W'(i);
    logic wr_hit_s;

    assign wr_hit_s = wr_ok_s & (wr_ch_i == CH_IDX);

    clkdiv_chan #(
      .CNT_W    (CNT_W),
      .DIV_INIT (DIV_RST[i*CNT_W +: CNT_W])
    ) u_chan (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .en_i     (en_i[i]),
`ifdef CLKDIV_SYNC_EN
      .sync_i   (sync_i),
`endif
      .wr_i     (wr_hit_s),
      .wr_div_i (wr_div_i),
      .tick_o   (tick_o[i]),
      .clk_o    (clk_out_o[i]),
      .pend_o   (pend_o[i])
    );
  end

endmodule
